// File: rtl/sram_responder.sv
// Responder model for the MEM-stage 16-bit SRAM port: backing array, fixed-latency read returns, misuse flag.
// Optional access counters are built when SRAM_ACCESS_STATS_EN is defined.
module sram_responder #(
  parameter int DEPTH_LOG2 = 16,
  parameter int READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SRAM_WE_N,
  input  logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        dq_drive,
  output logic        bus_conflict,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } mode_t;

  logic [15:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] index_s;
  logic [READ_LAT-1:0]   pipe_valid_r;
  logic [READ_LAT-1:0]   next_valid_s;
  logic [15:0]           pipe_data_r [READ_LAT];
  mode_t                 mode_r;
  logic                  conflict_s;

  assign index_s = SRAM_ADDR[DEPTH_LOG2-1:0];

  generate
    if (DEPTH_LOG2 < 18) begin : g_alias
      // Upper address bits alias onto the array and carry no information.
      logic unused_addr_s;
      assign unused_addr_s = ^SRAM_ADDR[17:DEPTH_LOG2];
    end
  endgenerate

  // A write arriving while any read is still in flight must discard those returns.
  assign conflict_s = (mode_r == READ) && !SRAM_WE_N && (|pipe_valid_r);

  // Valid bits shifted one stage; a write cycle enters as a bubble.
  always_comb begin
    next_valid_s    = '0;
    next_valid_s[0] = SRAM_WE_N;
    for (int i = 1; i < READ_LAT; i++) begin
      next_valid_s[i] = pipe_valid_r[i-1];
    end
  end

  // Storage array: writes commit outside reset, even on a conflict edge.
  always_ff @(posedge clk) begin
    if (!rst && !SRAM_WE_N) begin
      mem_r[index_s] <= SRAM_DQ;
    end
  end

  // Read data pipeline: sampled from the array at issue time, so later writes never alter it.
  always_ff @(posedge clk) begin
    pipe_data_r[0] <= mem_r[index_s];
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_data_r[i] <= pipe_data_r[i-1];
    end
  end

  // Mode tracker, pipeline valids and sticky conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_r <= '0;
      bus_conflict <= 1'b0;
      mode_r       <= IDLE;
    end else begin
      if (conflict_s) begin
        pipe_valid_r <= '0;
        bus_conflict <= 1'b1;
      end else begin
        pipe_valid_r <= next_valid_s;
      end
      case (mode_r)
        IDLE:    mode_r <= SRAM_WE_N ? READ : WRITE;
        READ:    mode_r <= SRAM_WE_N ? READ : WRITE;
        WRITE:   mode_r <= SRAM_WE_N ? READ : WRITE;
        default: mode_r <= IDLE;
      endcase
    end
  end

  // Drive is gated combinationally by the strobe so a write is never fought.
  assign dq_drive = pipe_valid_r[READ_LAT-1] & SRAM_WE_N;
  assign SRAM_DQ  = dq_drive ? pipe_data_r[READ_LAT-1] : 16'hzzzz;

`ifdef SRAM_ACCESS_STATS_EN
  logic [15:0] rd_cnt_r;
  logic [15:0] wr_cnt_r;

  // Saturating access counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_r <= 16'd0;
      wr_cnt_r <= 16'd0;
    end else if (SRAM_WE_N) begin
      if (rd_cnt_r != 16'hFFFF) rd_cnt_r <= rd_cnt_r + 16'd1;
    end else begin
      if (wr_cnt_r != 16'hFFFF) wr_cnt_r <= wr_cnt_r + 16'd1;
    end
  end

  assign rd_count = rd_cnt_r;
  assign wr_count = wr_cnt_r;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: four instances (READ_LAT 1..4) share one stimulus stream and are
// compared against a transaction-level model of issued reads, flushes and conflicts.
module tb_sram_responder;

`ifdef SRAM_ACCESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int MAXE = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_n = 1'b1;
  logic [17:0] addr = 18'd0;
  logic [15:0] wdata = 16'd0;
  logic        tb_drv = 1'b0;

  wire  [15:0] dq1, dq2, dq3, dq4;
  logic        drv  [1:4];
  logic        conf [1:4];
  logic [15:0] rdc  [1:4];
  logic [15:0] wrc  [1:4];

  assign dq1 = tb_drv ? wdata : 16'hzzzz;
  assign dq2 = tb_drv ? wdata : 16'hzzzz;
  assign dq3 = tb_drv ? wdata : 16'hzzzz;
  assign dq4 = tb_drv ? wdata : 16'hzzzz;

  always #5 clk = ~clk;

  sram_responder #(.DEPTH_LOG2(16), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .SRAM_WE_N(we_n), .SRAM_ADDR(addr), .SRAM_DQ(dq1),
    .dq_drive(drv[1]), .bus_conflict(conf[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));
  sram_responder #(.DEPTH_LOG2(16), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .SRAM_WE_N(we_n), .SRAM_ADDR(addr), .SRAM_DQ(dq2),
    .dq_drive(drv[2]), .bus_conflict(conf[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));
  sram_responder #(.DEPTH_LOG2(16), .READ_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .SRAM_WE_N(we_n), .SRAM_ADDR(addr), .SRAM_DQ(dq3),
    .dq_drive(drv[3]), .bus_conflict(conf[3]), .rd_count(rdc[3]), .wr_count(wrc[3]));
  sram_responder #(.DEPTH_LOG2(16), .READ_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .SRAM_WE_N(we_n), .SRAM_ADDR(addr), .SRAM_DQ(dq4),
    .dq_drive(drv[4]), .bus_conflict(conf[4]), .rd_count(rdc[4]), .wr_count(wrc[4]));

  // Reference model: per latency, which edges issued a live read and what word it captured.
  bit          iss_v [1:4][0:MAXE-1];
  bit          iss_k [1:4][0:MAXE-1];
  logic [15:0] iss_d [1:4][0:MAXE-1];
  bit          m_conf [1:4];
  logic [15:0] mem_m [int];
  int          m_rd = 0;
  int          m_wr = 0;
  int          edge_n = 0;

  logic        obs_drive [1:4];
  logic        obs_conf  [1:4];
  logic [15:0] obs_dq    [1:4];
  logic [15:0] obs_rd    [1:4];
  logic [15:0] obs_wr    [1:4];
  bit          exp_drive [1:4];
  bit          exp_known [1:4];
  logic [15:0] exp_dq    [1:4];
  bit          exp_conf  [1:4];
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;

  int ntotal = 0;
  int npass  = 0;

  task automatic model_edge(input logic r, input logic w, input logic [17:0] a, input logic [15:0] d);
    int e;
    bit any;
    e = edge_n;
    for (int l = 1; l <= 4; l++) begin
      any = 1'b0;
      for (int j = e - l; j < e; j++) begin
        if (j >= 0) any |= iss_v[l][j];
      end
      iss_v[l][e] = 1'b0;
      if (r) begin
        for (int j = e - l; j < e; j++) if (j >= 0) iss_v[l][j] = 1'b0;
        m_conf[l] = 1'b0;
      end else if (!w) begin
        if (any) begin
          m_conf[l] = 1'b1;
          for (int j = e - l; j < e; j++) if (j >= 0) iss_v[l][j] = 1'b0;
        end
      end else begin
        iss_v[l][e] = 1'b1;
        iss_k[l][e] = mem_m.exists(int'(a[15:0]));
        iss_d[l][e] = iss_k[l][e] ? mem_m[int'(a[15:0])] : 16'h0000;
      end
    end
    if (r) begin
      m_rd = 0;
      m_wr = 0;
    end else if (!w) begin
      mem_m[int'(a[15:0])] = d;
      if (m_wr < 65535) m_wr++;
    end else begin
      if (m_rd < 65535) m_rd++;
    end
  endtask

  // One clock: drive at negedge, sample outputs plus model expectations, then advance over the posedge.
  task automatic step(input logic r, input logic w, input logic [17:0] a, input logic [15:0] d);
    int i;
    @(negedge clk);
    rst = r; we_n = w; addr = a; wdata = d; tb_drv = ~w;
    #1;
    obs_dq[1] = dq1; obs_dq[2] = dq2; obs_dq[3] = dq3; obs_dq[4] = dq4;
    for (int l = 1; l <= 4; l++) begin
      obs_drive[l] = drv[l];
      obs_conf[l]  = conf[l];
      obs_rd[l]    = rdc[l];
      obs_wr[l]    = wrc[l];
      i = edge_n - l + 1;
      exp_drive[l] = 1'b0;
      exp_known[l] = 1'b0;
      exp_dq[l]    = 16'h0000;
      if (i >= 0) begin
        exp_drive[l] = iss_v[l][i] && w;
        exp_known[l] = iss_k[l][i];
        exp_dq[l]    = iss_d[l][i];
      end
      exp_conf[l] = m_conf[l];
    end
    exp_rd = STATS ? 16'(m_rd) : 16'd0;
    exp_wr = STATS ? 16'(m_wr) : 16'd0;
    @(posedge clk);
    edge_n++;
    model_edge(r, w, a, d);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 18'd0, 16'd0);
    step(1'b0, 1'b1, 18'd0, 16'd0);
    for (int l = 1; l <= 4; l++) begin
      ntotal++;
      if (obs_drive[l] !== 1'b0) $display("FAIL reset_drive lat%0d: got %b want 0", l, obs_drive[l]);
      else npass++;
      ntotal++;
      if (obs_conf[l] !== 1'b0) $display("FAIL reset_conflict lat%0d: got %b want 0", l, obs_conf[l]);
      else npass++;
      ntotal++;
      if (obs_rd[l] !== 16'd0 || obs_wr[l] !== 16'd0)
        $display("FAIL reset_counts lat%0d: got rd=%0d wr=%0d want 0/0", l, obs_rd[l], obs_wr[l]);
      else npass++;
    end
  endtask

  task automatic test_write_read();
    step(1'b1, 1'b1, 18'd0, 16'd0);
    step(1'b0, 1'b0, 18'h00010, 16'hBEEF);
    step(1'b0, 1'b1, 18'h00010, 16'd0);
    step(1'b0, 1'b1, 18'h00020, 16'd0);
    ntotal++;
    if (obs_drive[1] !== 1'b1 || obs_dq[1] !== 16'hBEEF)
      $display("FAIL write_read_lat1: got drive=%b dq=%h want 1/beef", obs_drive[1], obs_dq[1]);
    else npass++;
    ntotal++;
    if (obs_drive[2] !== 1'b0) $display("FAIL write_read_lat2_early: got drive=%b want 0", obs_drive[2]);
    else npass++;
    ntotal++;
    if (obs_rd[1] !== (STATS ? 16'd1 : 16'd0) || obs_wr[1] !== (STATS ? 16'd1 : 16'd0))
      $display("FAIL write_read_counts: got rd=%0d wr=%0d want %0d/%0d", obs_rd[1], obs_wr[1], STATS, STATS);
    else npass++;
    step(1'b0, 1'b1, 18'h00020, 16'd0);
    ntotal++;
    if (obs_drive[2] !== 1'b1 || obs_dq[2] !== 16'hBEEF)
      $display("FAIL write_read_lat2: got drive=%b dq=%h want 1/beef", obs_drive[2], obs_dq[2]);
    else npass++;
  endtask

  task automatic test_aliasing();
    step(1'b1, 1'b1, 18'd0, 16'd0);
    step(1'b0, 1'b0, 18'h10005, 16'h1234);
    step(1'b0, 1'b1, 18'h00005, 16'd0);
    step(1'b0, 1'b1, 18'h00005, 16'd0);
    ntotal++;
    if (obs_drive[1] !== 1'b1 || obs_dq[1] !== 16'h1234)
      $display("FAIL aliasing: got drive=%b dq=%h want 1/1234", obs_drive[1], obs_dq[1]);
    else npass++;
  endtask

  task automatic test_streaming();
    logic [15:0] want;
    step(1'b1, 1'b1, 18'd0, 16'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 18'(k), 16'(16'hA0 + k));
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 18'(k % 4), 16'd0);
      if (k >= 3) begin
        want = 16'(16'hA0 + ((k - 3) % 4));
        ntotal++;
        if (obs_drive[3] !== 1'b1 || obs_dq[3] !== want)
          $display("FAIL stream_lat3 k%0d: got drive=%b dq=%h want 1/%h", k, obs_drive[3], obs_dq[3], want);
        else npass++;
      end else begin
        ntotal++;
        if (obs_drive[3] !== 1'b0) $display("FAIL stream_lat3_early k%0d: got drive=%b want 0", k, obs_drive[3]);
        else npass++;
      end
    end
  endtask

  task automatic test_conflict();
    step(1'b1, 1'b1, 18'd0, 16'd0);
    step(1'b0, 1'b1, 18'd0, 16'd0);
    step(1'b0, 1'b0, 18'd1, 16'h5555);
    ntotal++;
    if (obs_drive[2] !== 1'b0 || obs_drive[1] !== 1'b0)
      $display("FAIL conflict_no_drive: got lat1=%b lat2=%b want 0/0", obs_drive[1], obs_drive[2]);
    else npass++;
    step(1'b0, 1'b1, 18'd1, 16'd0);
    ntotal++;
    if (obs_conf[2] !== 1'b1 || obs_drive[2] !== 1'b0)
      $display("FAIL conflict_set: got conf=%b drive=%b want 1/0", obs_conf[2], obs_drive[2]);
    else npass++;
    step(1'b0, 1'b1, 18'd1, 16'd0);
    step(1'b0, 1'b1, 18'd1, 16'd0);
    ntotal++;
    if (obs_drive[2] !== 1'b1 || obs_dq[2] !== 16'h5555)
      $display("FAIL conflict_write_kept: got drive=%b dq=%h want 1/5555", obs_drive[2], obs_dq[2]);
    else npass++;
    for (int l = 1; l <= 4; l++) begin
      ntotal++;
      if (obs_conf[l] !== 1'b1) $display("FAIL conflict_sticky lat%0d: got %b want 1", l, obs_conf[l]);
      else npass++;
    end
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 1'b1, 18'd0, 16'd0);
    step(1'b0, 1'b1, 18'd2, 16'd0);
    step(1'b0, 1'b1, 18'd3, 16'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 18'd0, 16'd0);
      if (k >= 1) begin
        for (int l = 1; l <= 4; l++) begin
          ntotal++;
          if (obs_drive[l] !== 1'b0) $display("FAIL reset_mid_read lat%0d k%0d: got drive=%b want 0", l, k, obs_drive[l]);
          else npass++;
        end
      end
    end
  endtask

  task automatic test_random();
    logic r, w;
    logic [17:0] a;
    step(1'b1, 1'b1, 18'd0, 16'd0);
    for (int k = 0; k < 16; k++)
      step(1'b0, 1'b0, {2'($urandom_range(0, 3)), 12'd0, 4'(k)}, 16'($urandom));
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      w = ($urandom_range(0, 9) < 7);
      a = {2'($urandom_range(0, 3)), 12'd0, 4'($urandom_range(0, 15))};
      step(r, w, a, 16'($urandom));
      for (int l = 1; l <= 4; l++) begin
        ntotal++;
        if (obs_drive[l] !== exp_drive[l])
          $display("FAIL rand_drive lat%0d n%0d: got %b want %b", l, n, obs_drive[l], exp_drive[l]);
        else npass++;
        if (exp_drive[l] && exp_known[l]) begin
          ntotal++;
          if (obs_dq[l] !== exp_dq[l]) $display("FAIL rand_data lat%0d n%0d: got %h want %h", l, n, obs_dq[l], exp_dq[l]);
          else npass++;
        end
        ntotal++;
        if (obs_conf[l] !== exp_conf[l])
          $display("FAIL rand_conflict lat%0d n%0d: got %b want %b", l, n, obs_conf[l], exp_conf[l]);
        else npass++;
        ntotal++;
        if (obs_rd[l] !== exp_rd || obs_wr[l] !== exp_wr)
          $display("FAIL rand_counts lat%0d n%0d: got %0d/%0d want %0d/%0d", l, n, obs_rd[l], obs_wr[l], exp_rd, exp_wr);
        else npass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_aliasing();
    test_streaming();
    test_conflict();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
